// File: rtl/axi4l_cmd_master_if.sv
// Bundle for axi4l_cmd_master: command/response stream plus AXI4-Lite bus.
// Ports: cmd_* / rsp_* stream, m_axi_* AW/W/B/AR/R channels.
interface axi4l_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;

    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one response out.
// Ports: clk, rst (sync, active-high), bus (axi4l_cmd_master_if.master).
module axi4l_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4l_cmd_master_if.master     bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        TO_EN ? CW'(TIMEOUT_CYCLES) : {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST =
        TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic          hit;
    logic          abort;
    logic          aw_left;
    logic          w_left;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        abort         = 1'b0;
        aw_left       = awvalid_q && !bus.m_axi_awready;
        w_left        = wvalid_q && !bus.m_axi_wready;
        // Saturating count; this cycle is the last one allowed in flight
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        hit     = TO_EN && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    wstrb_d     = bus.cmd_wstrb;
                    cnt_d       = '0;
                    if (bus.cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    // Also raises cmd_ready the first cycle out of reset
                    cmd_ready_d = 1'b1;
                end
            end
            WR_REQ: begin
                cnt_d     = cnt_inc;
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (hit) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                cnt_d = cnt_inc;
                if (bus.m_axi_bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = bus.m_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (hit) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                cnt_d = cnt_inc;
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end else if (hit) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                cnt_d = cnt_inc;
                if (bus.m_axi_rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = bus.m_axi_rresp;
                    rsp_rdata_d   = bus.m_axi_rdata;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (hit) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Protocol abort: release the bus and report a synthetic SLVERR
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = RSP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_rready  = rready_q;
endmodule
